// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RISC-V controller.
// Holds the state encoding, opcodes, ALU codes and mux select codes.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_EXECJALR = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALUY   = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // How the ALU decoder should interpret funct3/funct7_5 in the current state.
    typedef enum logic [1:0] {
        DEC_ADD    = 2'd0,
        DEC_RTYPE  = 2'd1,
        DEC_ITYPE  = 2'd2,
        DEC_BRANCH = 2'd3
    } dec_mode_t;

    function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
        case (opcode)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7_5 decode into an ALU operation code.
// Only R-type distinguishes sub from add; branches compare with sub or slt.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  dec_mode_t   mode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output logic [2:0]  ALUcontrol
);

    always_comb begin
        ALUcontrol = ALU_ADD;
        case (mode)
            DEC_RTYPE, DEC_ITYPE: begin
                case (funct3)
                    3'b000:  ALUcontrol = (mode == DEC_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111:  ALUcontrol = ALU_AND;
                    3'b110:  ALUcontrol = ALU_OR;
                    3'b100:  ALUcontrol = ALU_XOR;
                    3'b010:  ALUcontrol = ALU_SLT;
                    3'b011:  ALUcontrol = ALU_SLTU;
                    default: ALUcontrol = ALU_ADD;
                endcase
            end
            DEC_BRANCH: begin
                ALUcontrol = (funct3 == 3'b100 || funct3 == 3'b101) ? ALU_SLT : ALU_SUB;
            end
            default: ALUcontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for a multi-cycle RISC-V datapath.
// Outputs decode from the state register plus the held instruction fields.
module multi_cycle_controller
    import riscv_mc_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUcontrol,
    output logic [2:0]  IMMslc,
    output logic        illegal
);

    state_t    state_reg;
    dec_mode_t dec_mode;
    logic      branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:  state_reg <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_RTYPE:     state_reg <= S_EXECR;
                        OP_ITYPE:     state_reg <= S_EXECI;
                        OP_BRANCH:    state_reg <= S_BRANCH;
                        OP_JAL:       state_reg <= S_JAL;
                        OP_JALR:      state_reg <= S_EXECJALR;
                        OP_LUI:       state_reg <= S_LUI;
                        default:      state_reg <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state_reg <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state_reg <= S_MEMWB;
                S_MEMWB:    state_reg <= S_FETCH;
                S_MEMWRITE: state_reg <= S_FETCH;
                S_EXECR:    state_reg <= S_ALUWB;
                S_EXECI:    state_reg <= S_ALUWB;
                S_ALUWB:    state_reg <= S_FETCH;
                S_BRANCH:   state_reg <= S_FETCH;
                S_EXECJALR: state_reg <= S_JAL;
                S_JAL:      state_reg <= S_ALUWB;
                S_LUI:      state_reg <= S_FETCH;
                S_TRAP:     state_reg <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                default:    state_reg <= S_FETCH;
            endcase
        end
    end

    // Branch decision uses the zero flag of the compare issued in this same cycle.
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = ~zero;
            3'b101:  branch_taken = zero;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        case (state_reg)
            S_EXECR:  dec_mode = DEC_RTYPE;
            S_EXECI:  dec_mode = DEC_ITYPE;
            S_BRANCH: dec_mode = DEC_BRANCH;
            default:  dec_mode = DEC_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .mode       (dec_mode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .ALUcontrol (ALUcontrol)
    );

    assign IMMslc = imm_sel(opcode);

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REGB;
        illegal   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUY;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_EXECI, S_EXECJALR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR:  ALUSrcA = SRCA_REGA;
            S_ALUWB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_REGA;
                PCWrite = branch_taken;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                ResultSrc = RES_IMM;
                RegWrite  = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: vector table, random
// instruction stream against a step-indexed reference model, reset/trap corners.
module tb_multi_cycle_controller;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;

    logic       pcw, irw, memw, regw, adr, ill;
    logic [1:0] rs, asa, asb;
    logic [2:0] aluc, imm;
    logic       pcw0, irw0, memw0, regw0, adr0, ill0;
    logic [1:0] rs0, asa0, asb0;
    logic [2:0] aluc0, imm0;

    typedef struct packed {
        logic       pcw, irw, memw, regw, adr;
        logic [1:0] rs, asa, asb;
        logic [2:0] aluc, imm;
        logic       ill;
    } ctl_t;

    ctl_t obs, obs0;
    assign obs  = {pcw, irw, memw, regw, adr, rs, asa, asb, aluc, imm, ill};
    assign obs0 = {pcw0, irw0, memw0, regw0, adr0, rs0, asa0, asb0, aluc0, imm0, ill0};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_cycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .PCWrite(pcw), .IRWrite(irw), .MemWrite(memw), .RegWrite(regw), .AdrSrc(adr),
        .ResultSrc(rs), .ALUSrcA(asa), .ALUSrcB(asb), .ALUcontrol(aluc), .IMMslc(imm), .illegal(ill)
    );

    multi_cycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .PCWrite(pcw0), .IRWrite(irw0), .MemWrite(memw0), .RegWrite(regw0), .AdrSrc(adr0),
        .ResultSrc(rs0), .ALUSrcA(asa0), .ALUSrcB(asb0), .ALUcontrol(aluc0), .IMMslc(imm0), .illegal(ill0)
    );

    // ---------------- reference model ----------------
    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            SW:      return 3'b001;
            BR:      return 3'b010;
            JL:      return 3'b011;
            LU:      return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] funct_op(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b101;
            3'b011:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int model_lat(input logic [6:0] op);
        case (op)
            LW, JR:         return 5;
            SW, RT, IT, JL: return 4;
            default:        return 3;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000, 3'b101: return z;
            3'b001, 3'b100: return !z;
            default:        return 1'b0;
        endcase
    endfunction

    // Expected outputs at cycle 'step' of an instruction (step 0 = fetch).
    function automatic ctl_t expect_at(input logic [6:0] op, input logic [2:0] f3,
                                       input logic f7, input logic z, input int step);
        ctl_t e = '0;
        e.imm = imm_of(op);
        if (step == 0) begin
            e.irw = 1'b1; e.asb = 2'b10; e.rs = 2'b10; e.pcw = 1'b1;
        end else if (step == 1) begin
            e.asa = 2'b01; e.asb = 2'b01;
        end else begin
            case (op)
                LW: case (step)
                    2: begin e.asa = 2'b10; e.asb = 2'b01; end
                    3: e.adr = 1'b1;
                    default: begin e.rs = 2'b01; e.regw = 1'b1; end
                endcase
                SW: if (step == 2) begin e.asa = 2'b10; e.asb = 2'b01; end
                    else begin e.adr = 1'b1; e.memw = 1'b1; end
                RT: if (step == 2) begin e.asa = 2'b10; e.aluc = funct_op(f3, f7, 1'b1); end
                    else e.regw = 1'b1;
                IT: if (step == 2) begin e.asa = 2'b10; e.asb = 2'b01; e.aluc = funct_op(f3, f7, 1'b0); end
                    else e.regw = 1'b1;
                BR: begin
                    e.asa = 2'b10;
                    e.aluc = (f3 == 3'b100 || f3 == 3'b101) ? 3'b101 : 3'b001;
                    e.pcw = br_taken(f3, z);
                end
                JL: if (step == 2) begin e.asa = 2'b01; e.asb = 2'b10; e.pcw = 1'b1; end
                    else e.regw = 1'b1;
                JR: case (step)
                    2: begin e.asa = 2'b10; e.asb = 2'b01; end
                    3: begin e.asa = 2'b01; e.asb = 2'b10; e.pcw = 1'b1; end
                    default: e.regw = 1'b1;
                endcase
                LU: begin e.rs = 2'b11; e.regw = 1'b1; end
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    // ALU op of branches with unlisted funct3 is left open; only PCWrite matters there.
    function automatic ctl_t care_mask(input logic [6:0] op, input logic [2:0] f3, input int step);
        ctl_t m = '1;
        if (op == BR && step == 2 && !(f3 inside {3'b000, 3'b001, 3'b100, 3'b101}))
            m.aluc = 3'b000;
        return m;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_ctl(input string name, input ctl_t got, input ctl_t exp, input ctl_t m);
        checks++;
        if ((got & m) !== (exp & m)) begin
            failures++;
            $display("FAIL %s got=%05h expected=%05h", name, got & m, exp & m);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Entered at a negedge with both DUTs in FETCH; returns at a negedge in the next FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                             output int lat, output int npcw, output int nregw, output int nmemw,
                             output logic [2:0] aluc2);
        ctl_t e, m;
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
        #1;
        lat = 0; npcw = 0; nregw = 0; nmemw = 0; aluc2 = 3'b000;
        do begin
            e = expect_at(op, f3, f7, z, lat);
            m = care_mask(op, f3, lat);
            check_ctl($sformatf("op%b_f3%b_step%0d", op, f3, lat), obs, e, m);
            check_ctl($sformatf("p0_op%b_f3%b_step%0d", op, f3, lat), obs0, e, m);
            npcw += int'(obs.pcw); nregw += int'(obs.regw); nmemw += int'(obs.memw);
            if (lat == 2) aluc2 = obs.aluc;
            @(posedge clk); @(negedge clk);
            lat++;
        end while (obs.irw !== 1'b1 && lat < 12);
        if (lat >= 12) begin
            checks++; failures++;
            $display("FAIL timeout_op%b got=no_fetch expected=fetch_within_12", op);
        end
    endtask

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic f7; logic z;
        int lat; int npcw; int nregw; int nmemw; logic [2:0] aluc2;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog got=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, np, nr, nm;
        logic [2:0] a2;
        logic [6:0] legal[8];
        ctl_t ones;
        ones = '1;
        legal = '{LW, SW, RT, IT, BR, JL, JR, LU};

        vecs[0]  = '{RT, 3'b000, 1'b0, 1'b0, 4, 1, 1, 0, 3'b000};  // add
        vecs[1]  = '{RT, 3'b000, 1'b1, 1'b0, 4, 1, 1, 0, 3'b001};  // sub
        vecs[2]  = '{IT, 3'b111, 1'b0, 1'b0, 4, 1, 1, 0, 3'b010};  // andi
        vecs[3]  = '{IT, 3'b000, 1'b1, 1'b0, 4, 1, 1, 0, 3'b000};  // addi never subtracts
        vecs[4]  = '{LW, 3'b010, 1'b0, 1'b0, 5, 1, 1, 0, 3'b000};
        vecs[5]  = '{SW, 3'b010, 1'b0, 1'b0, 4, 1, 0, 1, 3'b000};
        vecs[6]  = '{BR, 3'b000, 1'b0, 1'b1, 3, 2, 0, 0, 3'b001};  // beq taken
        vecs[7]  = '{BR, 3'b001, 1'b0, 1'b1, 3, 1, 0, 0, 3'b001};  // bne not taken
        vecs[8]  = '{BR, 3'b100, 1'b0, 1'b0, 3, 2, 0, 0, 3'b101};  // blt taken
        vecs[9]  = '{BR, 3'b101, 1'b0, 1'b1, 3, 2, 0, 0, 3'b101};  // bge taken
        vecs[10] = '{JL, 3'b000, 1'b0, 1'b0, 4, 2, 1, 0, 3'b000};
        vecs[11] = '{JR, 3'b000, 1'b0, 1'b0, 5, 2, 1, 0, 3'b000};
        vecs[12] = '{LU, 3'b000, 1'b0, 1'b0, 3, 1, 1, 0, 3'b000};

        // Asynchronous reset: outputs must show fetch before any clock edge.
        #2 rst = 1'b1;
        #1;
        check_ctl("reset_async", obs, expect_at(opcode, 3'b000, 1'b0, 1'b0, 0), ones);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_ctl("reset_held", obs, expect_at(opcode, 3'b000, 1'b0, 1'b0, 0), ones);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, lat, np, nr, nm, a2);
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check_int($sformatf("vec%0d_pcwrite_cycles", i), np, vecs[i].npcw);
            check_int($sformatf("vec%0d_regwrite_cycles", i), nr, vecs[i].nregw);
            check_int($sformatf("vec%0d_memwrite_cycles", i), nm, vecs[i].nmemw);
            check_int($sformatf("vec%0d_aluctl", i), int'(a2), int'(vecs[i].aluc2));
            $display("vec %0d op=%b f3=%b f7=%b z=%b lat=%0d pcw=%0d regw=%0d memw=%0d", i,
                     vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, lat, np, nr, nm);
        end

        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic f7, z;
            op = legal[$urandom_range(0, 7)];
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            z  = 1'($urandom);
            run_instr(op, f3, f7, z, lat, np, nr, nm, a2);
            check_int($sformatf("rand%0d_latency", n), lat, model_lat(op));
            $display("rand %0d op=%b f3=%b f7=%b z=%b lat=%0d", n, op, f3, f7, z, lat);
        end

        // Reset while lw sits in MEMREAD: no write may leak, fetch resumes afterwards.
        opcode = LW; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
        #1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check_ctl("lw_memread", obs, expect_at(LW, 3'b010, 1'b0, 1'b0, 3), ones);
        #2 rst = 1'b1;
        #1;
        check_ctl("rst_mid_lw", obs, expect_at(LW, 3'b010, 1'b0, 1'b0, 0), ones);
        @(posedge clk); @(negedge clk);
        check_ctl("rst_mid_lw_held", obs, expect_at(LW, 3'b010, 1'b0, 1'b0, 0), ones);
        rst = 1'b0;
        run_instr(RT, 3'b110, 1'b0, 1'b0, lat, np, nr, nm, a2);
        check_int("resume_latency", lat, 4);
        $display("seq rst_mid_lw resume_lat=%0d", lat);

        // Illegal opcode: locking DUT holds TRAP, the non-locking one refetches.
        opcode = BAD; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0;
        #1;
        check_ctl("trap_fetch", obs, expect_at(BAD, 3'b000, 1'b0, 1'b0, 0), ones);
        @(posedge clk); @(negedge clk);
        check_ctl("trap_decode", obs, expect_at(BAD, 3'b000, 1'b0, 1'b0, 1), ones);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            check_ctl($sformatf("trap_hold%0d", k), obs, expect_at(BAD, 3'b000, 1'b0, 1'b0, 2 + k), ones);
            if (k == 0)
                check_ctl("p0_trap_once", obs0, expect_at(BAD, 3'b000, 1'b0, 1'b0, 2), ones);
            if (k == 1)
                check_ctl("p0_trap_refetch", obs0, expect_at(BAD, 3'b000, 1'b0, 1'b0, 0), ones);
        end
        #2 rst = 1'b1;
        #1;
        check_ctl("rst_from_trap", obs, expect_at(BAD, 3'b000, 1'b0, 1'b0, 0), ones);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        run_instr(LU, 3'b000, 1'b0, 1'b0, lat, np, nr, nm, a2);
        check_int("after_trap_latency", lat, 3);
        $display("seq trap_hold10 after_reset_lat=%0d", lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
